gold_fall_scheduler: RTL and testbench

//  Per-frame scheduler that decides when each gold bag may fall.
//  - Time-shares one dirt-map read port between N_BAGS gold blocks.
//  - Scans every bag after startOfFrame.
//  - Applies the wobble delay: a bag must be unsupported for WOBBLE_FRAMES

---
 rtl/gold_pkg.sv | 20 ++
 rtl/gold_wobble_counter.sv | 43 ++++
 rtl/gold_fall_scheduler.sv | 141 ++++++++++++++
 tb/tb_gold_fall_scheduler.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gold_pkg.sv
// Shared types and grid constants for the gold-bag fall scheduler.
package gold_pkg;

  localparam logic [3:0]  GOLD_EATEN = 4'd3;
  localparam int unsigned GRID_COLS  = 20;
  localparam int unsigned GRID_ROWS  = 15;
  localparam int unsigned CELL_SHIFT = 5;
  localparam int unsigned COL_W      = $clog2(GRID_COLS);
  localparam int unsigned ROW_W      = $clog2(GRID_ROWS);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EVAL, DONE} sched_state_t;

  // Pixel coordinate to cell index, rounding to the nearest cell.
  function automatic logic [6:0] cell_of(input logic [10:0] x);
    logic [11:0] s;
    s = {1'b0, x} + 12'd16;
    return s[11:CELL_SHIFT];
  endfunction

endpackage

// File: rtl/gold_wobble_counter.sv
// Per-bag wobble counter: decides can_fall from one support sample per scan.
module gold_wobble_counter #(
  parameter int unsigned WOBBLE_FRAMES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic eval,
  input  logic supported,
  input  logic aligned,
  input  logic eaten,
  output logic can_fall
);

  localparam int unsigned CNT_W = $clog2(WOBBLE_FRAMES + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      can_fall <= 1'b0;
    end else if (eval) begin
      if (eaten) begin
        cnt      <= '0;
        can_fall <= 1'b0;
      end else if (can_fall) begin
        // A falling bag only lands once it sits exactly on a cell boundary.
        if (supported && aligned) begin
          cnt      <= '0;
          can_fall <= 1'b0;
        end
      end else if (supported) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(WOBBLE_FRAMES - 1)) begin
        cnt      <= '0;
        can_fall <= 1'b1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/gold_fall_scheduler.sv
// Scans every gold bag once per frame over a shared dirt-map read port.
module gold_fall_scheduler
  import gold_pkg::*;
#(
  parameter int unsigned N_BAGS        = 4,
  parameter int unsigned WOBBLE_FRAMES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  startOfFrame,
  input  logic [11*N_BAGS-1:0]  goldTLX,
  input  logic [11*N_BAGS-1:0]  goldTLY,
  input  logic [4*N_BAGS-1:0]   gold_state,
  input  logic [10:0]           diggerTLX,
  input  logic [10:0]           diggerTLY,
  output logic                  map_rd_en,
  output logic [COL_W-1:0]      map_rd_col,
  output logic [ROW_W-1:0]      map_rd_row,
  input  logic                  map_rd_data,
  output logic [N_BAGS-1:0]     can_fall,
  output logic                  scan_busy,
  output logic                  scan_done
);

  localparam int unsigned IDX_W = (N_BAGS > 1) ? $clog2(N_BAGS) : 1;

  sched_state_t     state;
  logic [IDX_W-1:0] idx;
  logic             data_q;
  logic             floor_q;
  logic [6:0]       col_q;
  logic [6:0]       row_below_q;

  // Cell math for the bag about to be issued (bag 0 from IDLE, idx+1 from EVAL).
  logic [IDX_W-1:0] iss_idx;
  logic [10:0]      iss_tlx;
  logic [10:0]      iss_tly;
  logic [6:0]       iss_col;
  logic [6:0]       iss_row_below;
  logic             iss_floor;

  always_comb begin
    iss_idx       = (state == EVAL) ? idx + IDX_W'(1) : '0;
    iss_tlx       = goldTLX[11*iss_idx +: 11];
    iss_tly       = goldTLY[11*iss_idx +: 11];
    iss_col       = cell_of(iss_tlx);
    iss_row_below = 7'(iss_tly >> CELL_SHIFT) + 7'd1;
    iss_floor     = iss_row_below >= 7'(GRID_ROWS);
  end

  logic       supported;
  logic       aligned;
  logic       eaten;
  logic [6:0] dig_col;
  logic [6:0] dig_row;

  always_comb begin
    dig_col   = cell_of(diggerTLX);
    dig_row   = cell_of(diggerTLY);
    supported = floor_q || data_q || ((dig_col == col_q) && (dig_row == row_below_q));
    aligned   = goldTLY[11*idx +: CELL_SHIFT] == '0;
    eaten     = gold_state[4*idx +: 4] == GOLD_EATEN;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      data_q      <= 1'b0;
      floor_q     <= 1'b0;
      col_q       <= '0;
      row_below_q <= '0;
      map_rd_en   <= 1'b0;
      map_rd_col  <= '0;
      map_rd_row  <= '0;
      scan_busy   <= 1'b0;
      scan_done   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (startOfFrame) begin
            state       <= ISSUE;
            idx         <= '0;
            scan_busy   <= 1'b1;
            map_rd_en   <= 1'b1;
            col_q       <= iss_col;
            row_below_q <= iss_row_below;
            floor_q     <= iss_floor;
            map_rd_col  <= iss_col[COL_W-1:0];
            map_rd_row  <= iss_floor ? ROW_W'(GRID_ROWS - 1) : iss_row_below[ROW_W-1:0];
          end
        end
        ISSUE: begin
          map_rd_en <= 1'b0;
          state     <= WAIT;
        end
        WAIT: begin
          data_q <= map_rd_data;
          state  <= EVAL;
        end
        EVAL: begin
          if (idx == IDX_W'(N_BAGS - 1)) begin
            state     <= DONE;
            scan_done <= 1'b1;
          end else begin
            state       <= ISSUE;
            idx         <= iss_idx;
            map_rd_en   <= 1'b1;
            col_q       <= iss_col;
            row_below_q <= iss_row_below;
            floor_q     <= iss_floor;
            map_rd_col  <= iss_col[COL_W-1:0];
            map_rd_row  <= iss_floor ? ROW_W'(GRID_ROWS - 1) : iss_row_below[ROW_W-1:0];
          end
        end
        DONE: begin
          state     <= IDLE;
          idx       <= '0;
          scan_done <= 1'b0;
          scan_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar b = 0; b < N_BAGS; b++) begin : g_bag
    gold_wobble_counter #(
      .WOBBLE_FRAMES (WOBBLE_FRAMES)
    ) u_wobble (
      .clk       (clk),
      .reset     (reset),
      .eval      ((state == EVAL) && (idx == IDX_W'(b))),
      .supported (supported),
      .aligned   (aligned),
      .eaten     (eaten),
      .can_fall  (can_fall[b])
    );
  end

endmodule

// File: tb/tb_gold_fall_scheduler.sv
// Self-checking bench: directed scenarios plus randomized frames against a per-bag model.
module tb_gold_fall_scheduler;

  localparam int N = 4;
  localparam int W = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            startOfFrame;
  logic [11*N-1:0] goldTLX;
  logic [11*N-1:0] goldTLY;
  logic [4*N-1:0]  gold_state;
  logic [10:0]     diggerTLX;
  logic [10:0]     diggerTLY;
  logic            map_rd_en;
  logic [4:0]      map_rd_col;
  logic [3:0]      map_rd_row;
  logic            map_rd_data = 1'b0;
  logic [N-1:0]    can_fall;
  logic            scan_busy;
  logic            scan_done;

  int tlx[N];
  int tly[N];
  int gst[N];
  int dx;
  int dy;
  bit dirt[20][15];

  int m_cnt[N];
  bit m_cf[N];

  int total  = 0;
  int passed = 0;

  gold_fall_scheduler #(
    .N_BAGS        (N),
    .WOBBLE_FRAMES (W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (startOfFrame),
    .goldTLX      (goldTLX),
    .goldTLY      (goldTLY),
    .gold_state   (gold_state),
    .diggerTLX    (diggerTLX),
    .diggerTLY    (diggerTLY),
    .map_rd_en    (map_rd_en),
    .map_rd_col   (map_rd_col),
    .map_rd_row   (map_rd_row),
    .map_rd_data  (map_rd_data),
    .can_fall     (can_fall),
    .scan_busy    (scan_busy),
    .scan_done    (scan_done)
  );

  always #5 clk = ~clk;

  always_comb begin
    goldTLX    = '0;
    goldTLY    = '0;
    gold_state = '0;
    for (int i = 0; i < N; i++) begin
      goldTLX[11*i +: 11]  = 11'(tlx[i]);
      goldTLY[11*i +: 11]  = 11'(tly[i]);
      gold_state[4*i +: 4] = 4'(gst[i]);
    end
    diggerTLX = 11'(dx);
    diggerTLY = 11'(dy);
  end

  // Synchronous dirt-map RAM: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (map_rd_en && map_rd_col < 20 && map_rd_row < 15)
      map_rd_data <= dirt[map_rd_col][map_rd_row];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = m_cf[i];
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0;
      m_cf[i]  = 0;
    end
  endfunction

  function automatic void model_eval(input int i);
    int col, rb;
    bit fl, sup, al;
    col = (tlx[i] + 16) / 32;
    rb  = tly[i] / 32 + 1;
    fl  = rb >= 15;
    sup = fl || ((dx + 16) / 32 == col && (dy + 16) / 32 == rb) || (!fl && dirt[col][rb]);
    al  = (tly[i] % 32) == 0;
    if (gst[i] == 3) begin
      m_cf[i] = 0; m_cnt[i] = 0;
    end else if (m_cf[i]) begin
      if (sup && al) begin m_cf[i] = 0; m_cnt[i] = 0; end
    end else if (sup) begin
      m_cnt[i] = 0;
    end else if (m_cnt[i] == W - 1) begin
      m_cf[i] = 1; m_cnt[i] = 0;
    end else begin
      m_cnt[i]++;
    end
  endfunction

  // One full scan; with sof_hold the frame strobe stays high throughout.
  task automatic do_scan(input bit sof_hold);
    int col, rb;
    @(negedge clk); startOfFrame = 1'b1;
    @(negedge clk); if (!sof_hold) startOfFrame = 1'b0;
    for (int i = 0; i < N; i++) begin
      col = (tlx[i] + 16) / 32;
      rb  = tly[i] / 32 + 1;
      check("issue_rd_en", 32'(map_rd_en), 1);
      check("issue_col", 32'(map_rd_col), 32'(col));
      check("issue_row", 32'(map_rd_row), 32'(rb >= 15 ? 14 : rb));
      check("issue_busy", 32'(scan_busy), 1);
      @(negedge clk);
      check("wait_rd_en", 32'(map_rd_en), 0);
      @(negedge clk);
      check("pre_eval_cf", 32'(can_fall), model_vec());
      model_eval(i);
      @(negedge clk);
      check("post_eval_cf", 32'(can_fall), model_vec());
    end
    check("done_pulse", 32'(scan_done), 1);
    check("done_busy", 32'(scan_busy), 1);
    @(negedge clk);
    check("idle_done", 32'(scan_done), 0);
    check("idle_busy", 32'(scan_busy), 0);
    startOfFrame = 1'b0;
  endtask

  task automatic clear_dirt(input int density);
    for (int c = 0; c < 20; c++)
      for (int r = 0; r < 15; r++)
        dirt[c][r] = ($urandom_range(0, 99) < density);
  endtask

  initial begin
    reset        = 1'b1;
    startOfFrame = 1'b0;
    dx = 2000; dy = 2000;
    for (int i = 0; i < N; i++) begin
      tlx[i] = 64 * i + 300;
      tly[i] = 448;
      gst[i] = 0;
    end
    clear_dirt(0);
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_can_fall", 32'(can_fall), 0);
    check("rst_rd_en", 32'(map_rd_en), 0);
    check("rst_busy", 32'(scan_busy), 0);
    check("rst_done", 32'(scan_done), 0);
    reset = 1'b0;

    // Supported bag stays put for ten frames.
    tlx[0] = 160; tly[0] = 192; dirt[5][7] = 1'b1;
    repeat (10) do_scan(1'b0);
    check("t2_cf0", 32'(can_fall[0]), 0);

    // Wobble delay: rises on the third unsupported scan.
    dirt[5][7] = 1'b0;
    do_scan(1'b0); check("t3_scan1", 32'(can_fall[0]), 0);
    do_scan(1'b0); check("t3_scan2", 32'(can_fall[0]), 0);
    do_scan(1'b0); check("t3_scan3", 32'(can_fall[0]), 1);

    // Falling mid-cell keeps falling; lands on an aligned supported cell.
    dirt[5][7] = 1'b1; dirt[5][8] = 1'b1;
    tly[0] = 200; do_scan(1'b0); check("t4_mid_cell", 32'(can_fall[0]), 1);
    tly[0] = 224; do_scan(1'b0); check("t4_landed", 32'(can_fall[0]), 0);

    // Eaten bag drops its fall enable.
    tlx[1] = 320; tly[1] = 64;
    repeat (3) do_scan(1'b0);
    check("t5_falling", 32'(can_fall[1]), 1);
    gst[1] = 3; do_scan(1'b0); check("t5_eaten", 32'(can_fall[1]), 0);
    gst[1] = 0; tly[1] = 448;

    // Floor bag ignores dirt; digger supports bag0; held strobe ignored.
    tlx[2] = 96; tly[2] = 448; dirt[3][14] = 1'b0;
    tlx[0] = 160; tly[0] = 192; dirt[5][7] = 1'b0; dx = 160; dy = 224;
    repeat (2) do_scan(1'b1);
    repeat (2) do_scan(1'b0);
    check("t6_digger", 32'(can_fall[0]), 0);
    check("t6_floor", 32'(can_fall[2]), 0);

    // Reset in the middle of a scan while a bag is falling.
    dx = 2000; dy = 2000; tlx[3] = 500; tly[3] = 32;
    repeat (3) do_scan(1'b0);
    @(negedge clk); startOfFrame = 1'b1;
    @(negedge clk); startOfFrame = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check("t1_can_fall", 32'(can_fall), 0);
    check("t1_rd_en", 32'(map_rd_en), 0);
    check("t1_busy", 32'(scan_busy), 0);
    do_scan(1'b0);

    // Randomized frames.
    clear_dirt(30);
    for (int s = 0; s < 40; s++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          tlx[i] = $urandom_range(0, 620);
          tly[i] = $urandom_range(0, 1) ? 32 * $urandom_range(0, 14) : $urandom_range(0, 479);
        end
        gst[i] = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(4, 15);
      end
      if ($urandom_range(0, 3) == 0) begin
        dx = 32 * ((tlx[0] + 16) / 32);
        dy = 32 * (tly[0] / 32 + 1);
      end else begin
        dx = $urandom_range(0, 2047);
        dy = $urandom_range(0, 2047);
      end
      if ($urandom_range(0, 7) == 0) clear_dirt($urandom_range(10, 60));
      do_scan($urandom_range(0, 4) == 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
